connect4_game_ctrl: RTL

Game-state controller for the Connect-4 design. It sits directly upstream of the VGA panel renderer and turns button inputs into the board contents, cursor position, current player and result that the renderer draws. It owns the 6×7 board register, move legality, gravity drop, win/draw detection and restart.

---
 rtl/connect4_pkg.sv | 38 +++
 rtl/connect4_win_check.sv | 39 +++
 rtl/connect4_game_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, cell/winner codes and FSM states.
package connect4_pkg;

    localparam int unsigned ROWS      = 6;
    localparam int unsigned COLS      = 7;
    localparam int unsigned MAX_MOVES = 42;
    localparam int unsigned ROW_W     = 3;
    localparam int unsigned COL_W     = 3;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P0    = 2'b01,
        P1    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        WIN0 = 2'b01,
        WIN1 = 2'b10,
        DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        DROP  = 2'b01,
        CHECK = 2'b10,
        OVER  = 2'b11
    } state_t;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] panel_t;

    // Cell code a given player writes into the board.
    function automatic cell_t player_cell(input logic p);
        return p ? P1 : P0;
    endfunction

endpackage

// File: rtl/connect4_win_check.sv
// Combinational four-in-a-row detector over all 69 board windows for one cell code.
module connect4_win_check
    import connect4_pkg::*;
(
    input  logic [ROWS-1:0][COLS-1:0][1:0] panel,
    input  cell_t                          code,
    output logic                           win_c
);

    // Scan horizontal, vertical and both diagonal windows; any full match is a win.
    always_comb begin
        win_c = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c <= int'(COLS) - 4; c++) begin
                if (panel[r][c] == code && panel[r][c+1] == code &&
                    panel[r][c+2] == code && panel[r][c+3] == code)
                    win_c = 1'b1;
            end
        end
        for (int r = 0; r <= int'(ROWS) - 4; r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (panel[r][c] == code && panel[r+1][c] == code &&
                    panel[r+2][c] == code && panel[r+3][c] == code)
                    win_c = 1'b1;
            end
        end
        for (int r = 0; r <= int'(ROWS) - 4; r++) begin
            for (int c = 0; c <= int'(COLS) - 4; c++) begin
                if (panel[r][c] == code && panel[r+1][c+1] == code &&
                    panel[r+2][c+2] == code && panel[r+3][c+3] == code)
                    win_c = 1'b1;
                if (panel[r][c+3] == code && panel[r+1][c+2] == code &&
                    panel[r+2][c+1] == code && panel[r+3][c] == code)
                    win_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/connect4_game_ctrl.sv
// Connect-4 game-state controller: cursor, gravity drop, win/draw detection, restart.
module connect4_game_ctrl
    import connect4_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           left,
    input  logic                           right,
    input  logic                           put,
    input  logic                           restart,
    output logic [ROWS-1:0][COLS-1:0][1:0] panel,
    output logic [COLS-1:0]                play,
    output logic                           player,
    output logic [1:0]                     winner
);

    state_t                         state, state_d;
    logic [ROWS-1:0][COLS-1:0][1:0] panel_d;
    logic [COLS-1:0]                play_d;
    logic                           player_d;
    logic [1:0]                     winner_d;
    logic [COL_W-1:0]               col_q, col_d;
    logic [CNT_W-1:0]               moves, moves_d;
    logic                           left_q, right_q, put_q;
    logic                           left_e, right_e, put_e;
    logic [COL_W-1:0]               cur_col;
    logic [ROW_W-1:0]               drop_row;
    cell_t                          code;
    logic                           win_c;

    assign left_e  = left  & ~left_q;
    assign right_e = right & ~right_q;
    assign put_e   = put   & ~put_q;
    assign code    = player_cell(player);

    connect4_win_check u_win_check (
        .panel (panel),
        .code  (code),
        .win_c (win_c)
    );

    // One-hot cursor to column index.
    always_comb begin
        cur_col = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (play[c]) cur_col = COL_W'(c);
        end
    end

    // Priority encoder: lowest empty row in the latched column.
    always_comb begin
        drop_row = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (panel[r][col_q] == EMPTY) drop_row = ROW_W'(r);
        end
    end

    // Next-state and next-output logic; restart overrides everything.
    always_comb begin
        state_d  = state;
        panel_d  = panel;
        play_d   = play;
        player_d = player;
        winner_d = winner;
        col_d    = col_q;
        moves_d  = moves;
        if (restart) begin
            state_d  = PLAY;
            panel_d  = '0;
            play_d   = COLS'(1);
            player_d = 1'b0;
            winner_d = NONE;
            col_d    = '0;
            moves_d  = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (put_e) begin
                        if (panel[ROWS-1][cur_col] == EMPTY) begin
                            col_d   = cur_col;
                            state_d = DROP;
                        end
                    end else if (left_e && !right_e) begin
                        play_d = {play[0], play[COLS-1:1]};
                    end else if (right_e && !left_e) begin
                        play_d = {play[COLS-2:0], play[COLS-1]};
                    end
                end
                DROP: begin
                    panel_d[drop_row][col_q] = code;
                    if (moves != CNT_W'(MAX_MOVES)) moves_d = moves + CNT_W'(1);
                    state_d = CHECK;
                end
                CHECK: begin
                    if (win_c) begin
                        winner_d = player ? WIN1 : WIN0;
                        state_d  = OVER;
                    end else if (moves == CNT_W'(MAX_MOVES)) begin
                        winner_d = DRAW;
                        state_d  = OVER;
                    end else begin
                        player_d = ~player;
                        state_d  = PLAY;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    // State, board and output registers plus input edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PLAY;
            panel   <= '0;
            play    <= COLS'(1);
            player  <= 1'b0;
            winner  <= NONE;
            col_q   <= '0;
            moves   <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            put_q   <= 1'b0;
        end else begin
            state   <= state_d;
            panel   <= panel_d;
            play    <= play_d;
            player  <= player_d;
            winner  <= winner_d;
            col_q   <= col_d;
            moves   <= moves_d;
            left_q  <= left;
            right_q <= right;
            put_q   <= put;
        end
    end

endmodule
